// File: rtl/command_serializer_pkg.sv
// Shared constants for the byte-command link: opcodes, field widths, field-mask bits, serializer states.
// Opcode check is enabled by defining CMD_SERIALIZER_OPCODE_CHECK_EN (see command_serializer.sv).
package command_serializer_pkg;

    localparam int BLOCK_INSTR_WIDTH    = 32;
    localparam int BLOCK_REG_ADDR_WIDTH = 4;

    // Bit 3 of every opcode selects the target pipeline and is ignored when decoding.
    localparam logic [7:0] COMMAND_PIPE_SEL_MASK       = 8'hF7;
    localparam logic [7:0] COMMAND_WRITE_BLOCK_INSTR   = 8'h01;
    localparam logic [7:0] COMMAND_WRITE_BLOCK_REG     = 8'h02;
    localparam logic [7:0] COMMAND_UPDATE_BLOCK_REG    = 8'h03;
    localparam logic [7:0] COMMAND_COMMIT_REG_UPDATES  = 8'h04;
    localparam logic [7:0] COMMAND_ALLOC_DELAY         = 8'h05;
    localparam logic [7:0] COMMAND_SET_INPUT_GAIN      = 8'h06;
    localparam logic [7:0] COMMAND_SET_OUTPUT_GAIN     = 8'h07;
    localparam logic [7:0] COMMAND_SWAP_PIPELINES      = 8'h10;
    localparam logic [7:0] COMMAND_RESET_PIPELINE      = 8'h11;

    localparam int CMD_FIELD_BLOCK = 0;
    localparam int CMD_FIELD_REG   = 1;
    localparam int CMD_FIELD_DATA  = 2;
    localparam int CMD_FIELD_INSTR = 3;
    localparam int CMD_FIELD_DELAY = 4;
    localparam int CMD_FIELD_COUNT = 5;

    typedef enum logic [1:0] {
        SER_IDLE    = 2'd0,
        SER_PRESENT = 2'd1,
        SER_GAP     = 2'd2
    } ser_state_e;

endpackage

// File: rtl/command_serializer_field_decode.sv
// Combinational opcode -> field-mask decode, shared between the serializer and host-side checkers.
module cmd_field_decode
    import command_serializer_pkg::*;
(
    input  logic [7:0]                 opcode_i,
    output logic [CMD_FIELD_COUNT-1:0] field_mask_o,
    output logic                       known_o
);

    logic [7:0] base_op;

    // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
    always_comb begin
        base_op      = opcode_i & COMMAND_PIPE_SEL_MASK;
        field_mask_o = '0;
        known_o      = 1'b1;
        case (base_op)
            COMMAND_WRITE_BLOCK_INSTR: begin
                field_mask_o[CMD_FIELD_BLOCK] = 1'b1;
                field_mask_o[CMD_FIELD_INSTR] = 1'b1;
            end
            COMMAND_WRITE_BLOCK_REG, COMMAND_UPDATE_BLOCK_REG: begin
                field_mask_o[CMD_FIELD_BLOCK] = 1'b1;
                field_mask_o[CMD_FIELD_REG]   = 1'b1;
                field_mask_o[CMD_FIELD_DATA]  = 1'b1;
            end
            COMMAND_ALLOC_DELAY: begin
                field_mask_o[CMD_FIELD_DATA]  = 1'b1;
                field_mask_o[CMD_FIELD_DELAY] = 1'b1;
            end
            COMMAND_SET_INPUT_GAIN, COMMAND_SET_OUTPUT_GAIN: begin
                field_mask_o[CMD_FIELD_DATA] = 1'b1;
            end
            COMMAND_COMMIT_REG_UPDATES, COMMAND_SWAP_PIPELINES, COMMAND_RESET_PIPELINE: begin
                field_mask_o = '0;
            end
            default: known_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/command_serializer.sv
// Serializes one command descriptor into the controller's byte stream, one byte per `next`.
// Define CMD_SERIALIZER_OPCODE_CHECK_EN to drop unknown opcodes and pulse `invalid` instead.
module command_serializer
    import command_serializer_pkg::*;
#(
    parameter int n_blocks   = 32,
    parameter int data_width = 16
) (
    input  logic                                                  clk,
    input  logic                                                  reset,
    input  logic                                                  cmd_valid,
    output logic                                                  cmd_ready,
    input  logic [7:0]                                            cmd_opcode,
    input  logic [((n_blocks > 1) ? $clog2(n_blocks) : 1)-1:0]    cmd_block,
    input  logic [BLOCK_REG_ADDR_WIDTH-1:0]                       cmd_reg,
    input  logic [data_width-1:0]                                 cmd_data,
    input  logic [BLOCK_INSTR_WIDTH-1:0]                          cmd_instr,
    input  logic [2*data_width-1:0]                               cmd_delay,
    output logic [7:0]                                            out_byte,
    output logic                                                  out_ready,
    input  logic                                                  next,
    output logic                                                  busy,
    output logic                                                  done,
    output logic                                                  invalid,
    output logic                                                  proto_err
);

    localparam int DB        = data_width / 8;
    localparam int MAX_BYTES = 3 + 3 * DB + BLOCK_INSTR_WIDTH / 8;
    localparam int FW        = 8 * MAX_BYTES;
    localparam int CW        = $clog2(MAX_BYTES + 1);

    ser_state_e            state_q, state_d;
    logic [FW-1:0]         frame_q, frame_d;
    logic [CW-1:0]         remain_q, remain_d;
    logic [7:0]            out_byte_q, out_byte_d;
    logic                  out_ready_q, out_ready_d;
    logic                  done_q, done_d;
    logic                  invalid_q, invalid_d;
    logic                  proto_err_q, proto_err_d;

    logic [CMD_FIELD_COUNT-1:0] raw_mask, mask;
    logic                       known;
    logic [FW-1:0]              frame_acc, frame_new;
    logic [CW-1:0]              frame_len;

    cmd_field_decode u_decode (
        .opcode_i     (cmd_opcode),
        .field_mask_o (raw_mask),
        .known_o      (known)
    );

    // Unknown opcodes carry no fields regardless of how the decoder treats them.
    assign mask = known ? raw_mask : '0;

    // Right-append each present field, then left-align so bytes shift out MSB-first.
    always_comb begin
        frame_acc = FW'(cmd_opcode);
        frame_len = CW'(1);
        if (mask[CMD_FIELD_BLOCK]) begin
            frame_acc = (frame_acc << 8) | FW'(cmd_block);
            frame_len = frame_len + CW'(1);
        end
        if (mask[CMD_FIELD_REG]) begin
            frame_acc = (frame_acc << 8) | FW'(cmd_reg);
            frame_len = frame_len + CW'(1);
        end
        if (mask[CMD_FIELD_DATA]) begin
            frame_acc = (frame_acc << data_width) | FW'(cmd_data);
            frame_len = frame_len + CW'(DB);
        end
        if (mask[CMD_FIELD_INSTR]) begin
            frame_acc = (frame_acc << BLOCK_INSTR_WIDTH) | FW'(cmd_instr);
            frame_len = frame_len + CW'(BLOCK_INSTR_WIDTH / 8);
        end
        if (mask[CMD_FIELD_DELAY]) begin
            frame_acc = (frame_acc << (2 * data_width)) | FW'(cmd_delay);
            frame_len = frame_len + CW'(2 * DB);
        end
        frame_new = frame_acc << (8 * (MAX_BYTES - int'(frame_len)));
    end

    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        remain_d    = remain_q;
        out_byte_d  = out_byte_q;
        out_ready_d = out_ready_q;
        done_d      = 1'b0;
        invalid_d   = 1'b0;
        proto_err_d = next && !out_ready_q;
        case (state_q)
            SER_IDLE: begin
                if (cmd_valid) begin
`ifdef CMD_SERIALIZER_OPCODE_CHECK_EN
                    if (!known) begin
                        invalid_d = 1'b1;
                    end else begin
                        out_byte_d  = cmd_opcode;
                        out_ready_d = 1'b1;
                        frame_d     = frame_new << 8;
                        remain_d    = frame_len - CW'(1);
                        state_d     = SER_PRESENT;
                    end
`else
                    out_byte_d  = cmd_opcode;
                    out_ready_d = 1'b1;
                    frame_d     = frame_new << 8;
                    remain_d    = frame_len - CW'(1);
                    state_d     = SER_PRESENT;
`endif
                end
            end
            SER_PRESENT: begin
                if (next) begin
                    out_ready_d = 1'b0;
                    if (remain_q == '0) begin
                        done_d  = 1'b1;
                        state_d = SER_IDLE;
                    end else begin
                        state_d = SER_GAP;
                    end
                end
            end
            SER_GAP: begin
                out_byte_d  = frame_q[FW-1 -: 8];
                frame_d     = frame_q << 8;
                remain_d    = remain_q - CW'(1);
                out_ready_d = 1'b1;
                state_d     = SER_PRESENT;
            end
            default: state_d = SER_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= SER_IDLE;
            frame_q     <= '0;
            remain_q    <= '0;
            out_byte_q  <= '0;
            out_ready_q <= 1'b0;
            done_q      <= 1'b0;
            invalid_q   <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            remain_q    <= remain_d;
            out_byte_q  <= out_byte_d;
            out_ready_q <= out_ready_d;
            done_q      <= done_d;
            invalid_q   <= invalid_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign cmd_ready = (state_q == SER_IDLE);
    assign busy      = (state_q != SER_IDLE);
    assign out_byte  = out_byte_q;
    assign out_ready = out_ready_q;
    assign done      = done_q;
    assign invalid   = invalid_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_command_serializer.sv
// Self-checking bench for command_serializer: a byte-queue reference model plus a controller-side consumer.
module tb_command_serializer;
    import command_serializer_pkg::*;

    localparam int N_BLOCKS = 32;
    localparam int DW       = 16;
    localparam int BW       = $clog2(N_BLOCKS);
    localparam int DB       = DW / 8;
    localparam int IB       = BLOCK_INSTR_WIDTH / 8;

    logic                            clk = 1'b0;
    logic                            reset = 1'b0;
    logic                            cmd_valid = 1'b0;
    logic                            next = 1'b0;
    logic [7:0]                      cmd_opcode = '0;
    logic [BW-1:0]                   cmd_block = '0;
    logic [BLOCK_REG_ADDR_WIDTH-1:0] cmd_reg = '0;
    logic [DW-1:0]                   cmd_data = '0;
    logic [BLOCK_INSTR_WIDTH-1:0]    cmd_instr = '0;
    logic [2*DW-1:0]                 cmd_delay = '0;
    logic                            cmd_ready, out_ready, busy, done, invalid, proto_err;
    logic [7:0]                      out_byte;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];

    command_serializer #(.n_blocks(N_BLOCKS), .data_width(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_opcode (cmd_opcode),
        .cmd_block  (cmd_block),
        .cmd_reg    (cmd_reg),
        .cmd_data   (cmd_data),
        .cmd_instr  (cmd_instr),
        .cmd_delay  (cmd_delay),
        .out_byte   (out_byte),
        .out_ready  (out_ready),
        .next       (next),
        .busy       (busy),
        .done       (done),
        .invalid    (invalid),
        .proto_err  (proto_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: the byte list the controller should see for a descriptor.
    task automatic build_expected(input logic [7:0] op, input logic [BW-1:0] blk,
                                  input logic [BLOCK_REG_ADDR_WIDTH-1:0] rg, input logic [DW-1:0] data,
                                  input logic [BLOCK_INSTR_WIDTH-1:0] instr, input logic [2*DW-1:0] dly);
        logic [7:0] m;
        bit has_blk, has_reg, has_data, has_instr, has_dly;
        m         = op & 8'hF7;
        has_blk   = (m == COMMAND_WRITE_BLOCK_INSTR) || (m == COMMAND_WRITE_BLOCK_REG) || (m == COMMAND_UPDATE_BLOCK_REG);
        has_reg   = (m == COMMAND_WRITE_BLOCK_REG) || (m == COMMAND_UPDATE_BLOCK_REG);
        has_data  = has_reg || (m == COMMAND_ALLOC_DELAY) || (m == COMMAND_SET_INPUT_GAIN) || (m == COMMAND_SET_OUTPUT_GAIN);
        has_instr = (m == COMMAND_WRITE_BLOCK_INSTR);
        has_dly   = (m == COMMAND_ALLOC_DELAY);
        exp_q = {};
        exp_q.push_back(op);
        if (has_blk) exp_q.push_back(8'(blk));
        if (has_reg) exp_q.push_back(8'(rg));
        if (has_data)  for (int b = DB - 1; b >= 0; b--) exp_q.push_back(8'(data >> (8 * b)));
        if (has_instr) for (int b = IB - 1; b >= 0; b--) exp_q.push_back(8'(instr >> (8 * b)));
        if (has_dly)   for (int b = 2 * DB - 1; b >= 0; b--) exp_q.push_back(8'(dly >> (8 * b)));
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [BW-1:0] blk,
                            input logic [BLOCK_REG_ADDR_WIDTH-1:0] rg, input logic [DW-1:0] data,
                            input logic [BLOCK_INSTR_WIDTH-1:0] instr, input logic [2*DW-1:0] dly,
                            output int waited);
        waited = 0;
        while (cmd_ready !== 1'b1 && waited < 50) begin
            tick();
            waited++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL cmd_ready_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, waited);
        end
        build_expected(op, blk, rg, data, instr, dly);
        cmd_valid = 1'b1; cmd_opcode = op; cmd_block = blk; cmd_reg = rg;
        cmd_data = data; cmd_instr = instr; cmd_delay = dly;
        tick();
        cmd_valid  = 1'b0;
        cmd_opcode = 8'($urandom); cmd_block = BW'($urandom); cmd_reg = BLOCK_REG_ADDR_WIDTH'($urandom);
        cmd_data   = DW'($urandom); cmd_instr = $urandom; cmd_delay = $urandom;
    endtask

    // Acts as the controller: checks each presented byte, acks after ack_delay cycles,
    // verifies the one-cycle gap, and optionally fires a spurious next inside the gap.
    task automatic consume_frame(input int n_bytes, input int ack_delay, input bit spurious);
        for (int i = 0; i < n_bytes; i++) begin
            checks++;
            if (out_ready !== 1'b1 || out_byte !== exp_q[i]) begin
                errors++;
                $display("FAIL byte[%0d]: out_ready=%b out_byte=%h, required 1 / %h", i, out_ready, out_byte, exp_q[i]);
            end
            for (int d = 0; d < ack_delay; d++) begin
                tick();
                checks++;
                if (out_ready !== 1'b1 || out_byte !== exp_q[i] || done !== 1'b0) begin
                    errors++;
                    $display("FAIL hold[%0d]: out_ready=%b out_byte=%h done=%b, required 1 / %h / 0",
                             i, out_ready, out_byte, done, exp_q[i]);
                end
            end
            next = 1'b1;
            tick();
            next = 1'b0;
            checks++;
            if (out_ready !== 1'b0) begin
                errors++;
                $display("FAIL gap[%0d]: out_ready=%b, required 0", i, out_ready);
            end
            if (i == exp_q.size() - 1) begin
                checks++;
                if (done !== 1'b1 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL done: done=%b cmd_ready=%b busy=%b, required 1 1 0", done, cmd_ready, busy);
                end
            end else begin
                checks++;
                if (done !== 1'b0) begin
                    errors++;
                    $display("FAIL early_done[%0d]: done=%b, required 0", i, done);
                end
                if (spurious && i < n_bytes - 1) begin
                    next = 1'b1;
                    tick();
                    next = 1'b0;
                    checks++;
                    if (proto_err !== 1'b1) begin
                        errors++;
                        $display("FAIL proto_err[%0d]: proto_err=%b, required 1", i, proto_err);
                    end
                end else if (i < n_bytes - 1) begin
                    tick();
                end
            end
        end
    endtask

    task automatic check_done_cleared();
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_single: done=%b, required 0", done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) tick();
        checks++;
        if (cmd_ready !== 1'b1 || out_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            invalid !== 1'b0 || proto_err !== 1'b0 || out_byte !== 8'h00) begin
            errors++;
            $display("FAIL reset: rdy=%b ord=%b busy=%b done=%b inv=%b perr=%b byte=%h, required 1 0 0 0 0 0 00",
                     cmd_ready, out_ready, busy, done, invalid, proto_err, out_byte);
        end
        #3 reset = 1'b1;
        tick();
    endtask

    task automatic test_write_block_reg();
        int w;
        send_cmd(COMMAND_WRITE_BLOCK_REG, 5'd5, 4'd3, 16'hBEEF, 32'h0, 32'h0, w);
        consume_frame(exp_q.size(), 0, 1'b0);
        check_done_cleared();
    endtask

    task automatic test_alloc_delay();
        int w;
        send_cmd(COMMAND_ALLOC_DELAY | 8'h08, 5'd0, 4'd0, 16'h1234, 32'h0, 32'h0001F400, w);
        consume_frame(exp_q.size(), 1, 1'b0);
        check_done_cleared();
    endtask

    task automatic test_back_to_back();
        int w;
        send_cmd(COMMAND_SWAP_PIPELINES, 5'd0, 4'd0, 16'h0, 32'h0, 32'h0, w);
        consume_frame(exp_q.size(), 0, 1'b0);
        send_cmd(COMMAND_WRITE_BLOCK_INSTR, 5'd17, 4'd0, 16'h0, $urandom, 32'h0, w);
        checks++;
        if (w != 0) begin
            errors++;
            $display("FAIL back_to_back_accept: waited=%0d cycles, required 0", w);
        end
        consume_frame(exp_q.size(), 0, 1'b0);
        check_done_cleared();
    endtask

    task automatic test_delayed_ack_spurious();
        int w;
        send_cmd(COMMAND_UPDATE_BLOCK_REG, BW'($urandom), BLOCK_REG_ADDR_WIDTH'($urandom), DW'($urandom),
                 32'h0, 32'h0, w);
        consume_frame(exp_q.size(), 10, 1'b1);
        check_done_cleared();
    endtask

    task automatic test_reset_mid_frame();
        int w;
        send_cmd(COMMAND_ALLOC_DELAY, 5'd0, 4'd0, 16'hA55A, 32'h0, 32'hCAFEF00D, w);
        consume_frame(2, 0, 1'b0);
        tick();
        #2 reset = 1'b0;
        #1;
        checks++;
        if (out_ready !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: out_ready=%b cmd_ready=%b busy=%b, required 0 1 0", out_ready, cmd_ready, busy);
        end
        #3 reset = 1'b1;
        tick();
        checks++;
        if (cmd_ready !== 1'b1 || out_ready !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: cmd_ready=%b out_ready=%b, required 1 0", cmd_ready, out_ready);
        end
        send_cmd(COMMAND_SET_INPUT_GAIN, 5'd0, 4'd0, 16'h7E81, 32'h0, 32'h0, w);
        consume_frame(exp_q.size(), 0, 1'b0);
        check_done_cleared();
    endtask

    task automatic test_random();
        logic [7:0] ops [9];
        logic [7:0] op;
        int w;
        ops = '{COMMAND_WRITE_BLOCK_INSTR, COMMAND_WRITE_BLOCK_REG, COMMAND_UPDATE_BLOCK_REG,
                COMMAND_COMMIT_REG_UPDATES, COMMAND_ALLOC_DELAY, COMMAND_SET_INPUT_GAIN,
                COMMAND_SET_OUTPUT_GAIN, COMMAND_SWAP_PIPELINES, COMMAND_RESET_PIPELINE};
        for (int n = 0; n < 30; n++) begin
            op = ops[$urandom_range(0, 8)] | (($urandom_range(0, 1) != 0) ? 8'h08 : 8'h00);
            send_cmd(op, BW'($urandom), BLOCK_REG_ADDR_WIDTH'($urandom), DW'($urandom),
                     $urandom, $urandom, w);
            consume_frame(exp_q.size(), $urandom_range(0, 3), $urandom_range(0, 1) != 0);
            if ($urandom_range(0, 1) != 0) tick();
        end
    endtask

    task automatic test_unknown_opcode();
        int w;
        send_cmd(8'hFF, 5'd0, 4'd0, 16'h0, 32'h0, 32'h0, w);
`ifdef CMD_SERIALIZER_OPCODE_CHECK_EN
        checks++;
        if (invalid !== 1'b1 || out_ready !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL invalid_pulse: invalid=%b out_ready=%b cmd_ready=%b busy=%b, required 1 0 1 0",
                     invalid, out_ready, cmd_ready, busy);
        end
        tick();
        checks++;
        if (invalid !== 1'b0 || out_ready !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL invalid_after: invalid=%b out_ready=%b done=%b, required 0 0 0", invalid, out_ready, done);
        end
`else
        checks++;
        if (invalid !== 1'b0) begin
            errors++;
            $display("FAIL invalid_tied: invalid=%b, required 0", invalid);
        end
        consume_frame(exp_q.size(), 0, 1'b0);
        check_done_cleared();
`endif
    endtask

    initial begin
        test_reset();
        test_write_block_reg();
        test_alloc_delay();
        test_back_to_back();
        test_delayed_ack_spurious();
        test_reset_mid_frame();
        test_unknown_opcode();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
